// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pkg
//  Purpose  : Shared register-file geometry, reused by the file, the hazard
//             logic and the write-back queue.
//  Revision : 1.0  initial release
// ============================================================================
package reg_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/reg_wb_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_queue_if
//  Purpose  : WB-stage request, register-file write port and read-forwarding
//             signals of the write-back queue.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_wb_queue_if
  import reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid_i;
  logic          wb_ready_o;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic          port_en_i;
  logic [AW-1:0] RDaddr_o;
  logic [DW-1:0] RDdata_o;
  logic          RegWrite_o;
  logic [AW-1:0] RSaddr_i;
  logic [AW-1:0] RTaddr_i;
  logic          RShit_o;
  logic [DW-1:0] RSfwd_o;
  logic          RThit_o;
  logic [DW-1:0] RTfwd_o;
  logic [CW-1:0] count_o;

  modport master (
    output wb_valid_i, wb_addr_i, wb_data_i, port_en_i, RSaddr_i, RTaddr_i,
    input  wb_ready_o, RDaddr_o, RDdata_o, RegWrite_o,
    input  RShit_o, RSfwd_o, RThit_o, RTfwd_o, count_o
  );

  modport slave (
    input  wb_valid_i, wb_addr_i, wb_data_i, port_en_i, RSaddr_i, RTaddr_i,
    output wb_ready_o, RDaddr_o, RDdata_o, RegWrite_o,
    output RShit_o, RSfwd_o, RThit_o, RTfwd_o, count_o
  );

endinterface
`default_nettype wire

// File: rtl/reg_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module   : reg_fwd_match
//  Purpose  : Priority match of one read address against N pending entries;
//             entry 0 is the youngest and wins.
//  Revision : 1.0  initial release
// ============================================================================
module reg_fwd_match
  import reg_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic [AW-1:0]         i_rd_addr,
  input  logic [N-1:0][AW-1:0]  i_ent_addr,
  input  logic [N-1:0][DW-1:0]  i_ent_data,
  input  logic [N-1:0]          i_ent_valid,
  output logic                  o_hit,
  output logic [DW-1:0]         o_data
);

  logic w_nonzero;

  assign w_nonzero = (i_rd_addr != AW'(REG_ZERO));

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_nonzero && i_ent_valid[k] && (i_ent_addr[k] == i_rd_addr)) begin
        o_hit  = 1'b1;
        o_data = i_ent_data[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wb_queue
//  Purpose  : FIFO of pending register write-backs replayed onto the single
//             register-file write port, with youngest-first read forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module reg_wb_queue
  import reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic           clk_i,
  input  logic           rst_i,
  reg_wb_queue_if.slave  bus
);

  localparam int                c_pw   = $clog2(DEPTH);
  localparam int                c_cw   = c_pw + 1;
  localparam logic [c_cw-1:0]   c_full = c_cw'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [DEPTH-1:0]         r_valid;
  logic [c_pw-1:0]          r_rd;
  logic [c_pw-1:0]          r_wr;
  logic [c_cw-1:0]          r_count;

  logic                     w_ready;
  logic                     w_push;
  logic                     w_pop;

  logic [DEPTH-1:0][AW-1:0] w_ord_addr;
  logic [DEPTH-1:0][DW-1:0] w_ord_data;
  logic [DEPTH-1:0]         w_ord_valid;

  assign w_ready = (r_count != c_full);
  // Requests to $0 complete the handshake but never occupy an entry.
  assign w_push  = bus.wb_valid_i && w_ready && (bus.wb_addr_i != AW'(REG_ZERO));
  assign w_pop   = bus.port_en_i && (r_count != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd] <= 1'b0;
        r_rd          <= r_rd + c_pw'(1);
      end
      if (w_push) begin
        r_valid[r_wr] <= 1'b1;
        r_wr          <= r_wr + c_pw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: an entry is only observed while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wr] <= bus.wb_addr_i;
      r_data[r_wr] <= bus.wb_data_i;
    end
  end

  // Rotate storage so index 0 is the most recently written slot.
  for (genvar k = 0; k < DEPTH; k++) begin : g_order
    logic [c_pw-1:0] w_idx;
    assign w_idx          = r_wr - c_pw'(k + 1);
    assign w_ord_addr[k]  = r_addr[w_idx];
    assign w_ord_data[k]  = r_data[w_idx];
    assign w_ord_valid[k] = r_valid[w_idx];
  end

  reg_fwd_match #(
    .N  (DEPTH),
    .AW (AW),
    .DW (DW)
  ) u_rs_match (
    .i_rd_addr   (bus.RSaddr_i),
    .i_ent_addr  (w_ord_addr),
    .i_ent_data  (w_ord_data),
    .i_ent_valid (w_ord_valid),
    .o_hit       (bus.RShit_o),
    .o_data      (bus.RSfwd_o)
  );

  reg_fwd_match #(
    .N  (DEPTH),
    .AW (AW),
    .DW (DW)
  ) u_rt_match (
    .i_rd_addr   (bus.RTaddr_i),
    .i_ent_addr  (w_ord_addr),
    .i_ent_data  (w_ord_data),
    .i_ent_valid (w_ord_valid),
    .o_hit       (bus.RThit_o),
    .o_data      (bus.RTfwd_o)
  );

  assign bus.wb_ready_o = w_ready;
  assign bus.RegWrite_o = w_pop;
  assign bus.RDaddr_o   = r_addr[r_rd];
  assign bus.RDdata_o   = r_data[r_rd];
  assign bus.count_o    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_wb_queue
//  Purpose  : Self-checking bench for reg_wb_queue against a queue-based
//             model of pending writes and the register file.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  ent_t        q[$];
  logic [31:0] rf_ref [32];
  logic [31:0] rf_dut [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == a) begin
          hit = 1'b1;
          d   = q[i].d;
          break;
        end
      end
    end
  endfunction

  task automatic check_read(input string tag, input logic [4:0] a, input logic act_hit,
                            input logic [31:0] act_fwd);
    logic        h;
    logic [31:0] d;
    model_lookup(a, h, d);
    check({tag, "_hit"}, 32'(act_hit), 32'(h));
    if (h) check({tag, "_fwd"}, act_fwd, d);
    check({tag, "_view"}, act_hit ? act_fwd : rf_dut[a], h ? d : rf_ref[a]);
  endtask

  // One clock: drive at negedge, check combinational outputs, then advance model at posedge.
  task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d, input logic pe,
                       input logic [4:0] rs, input logic [4:0] rt);
    logic        exp_ready;
    logic        exp_we;
    logic        we_s;
    logic [4:0]  ra_s;
    logic [31:0] rd_s;
    ent_t        e;
    @(negedge clk);
    bus.wb_valid_i = v;
    bus.wb_addr_i  = a;
    bus.wb_data_i  = d;
    bus.port_en_i  = pe;
    bus.RSaddr_i   = rs;
    bus.RTaddr_i   = rt;
    #1;
    exp_ready = (q.size() != DEPTH);
    exp_we    = pe && (q.size() != 0);
    check("ready", 32'(bus.wb_ready_o), 32'(exp_ready));
    check("regwrite", 32'(bus.RegWrite_o), 32'(exp_we));
    check("count", 32'(bus.count_o), 32'(q.size()));
    if (exp_we) begin
      check("rd_addr", 32'(bus.RDaddr_o), 32'(q[0].a));
      check("rd_data", bus.RDdata_o, q[0].d);
    end
    check_read("rs", rs, bus.RShit_o, bus.RSfwd_o);
    check_read("rt", rt, bus.RThit_o, bus.RTfwd_o);
    we_s = bus.RegWrite_o;
    ra_s = bus.RDaddr_o;
    rd_s = bus.RDdata_o;
    @(posedge clk);
    if (we_s) rf_dut[ra_s] = rd_s;
    if (exp_we) begin
      e = q.pop_front();
      rf_ref[e.a] = e.d;
    end
    if (v && exp_ready && (a != 5'd0)) begin
      e.a = a;
      e.d = d;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    #1;
    check("drain_count", 32'(bus.count_o), 32'd0);
  endtask

  task automatic compare_rf();
    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), rf_dut[i], rf_ref[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        v;
    logic        pe;
    logic [4:0]  a;
    logic [4:0]  rs;
    logic [4:0]  rt;
    for (int i = 0; i < 32; i++) begin
      rf_ref[i] = '0;
      rf_dut[i] = '0;
    end
    bus.wb_valid_i = 1'b0;
    bus.wb_addr_i  = '0;
    bus.wb_data_i  = '0;
    bus.port_en_i  = 1'b1;
    bus.RSaddr_i   = 5'd5;
    bus.RTaddr_i   = 5'd6;

    // Reset state
    #12;
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_ready", 32'(bus.wb_ready_o), 32'd1);
    check("rst_regwrite", 32'(bus.RegWrite_o), 32'd0);
    check("rst_rshit", 32'(bus.RShit_o), 32'd0);
    check("rst_rthit", 32'(bus.RThit_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Buffered writes with the port blocked, then forwarding
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd6);
    cycle(1'b1, 5'd6, 32'h22, 1'b0, 5'd5, 5'd6);
    cycle(1'b1, 5'd5, 32'h33, 1'b0, 5'd5, 5'd6);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd6);
    #1;
    check("t2_count", 32'(bus.count_o), 32'd3);
    check("t2_rshit", 32'(bus.RShit_o), 32'd1);
    check("t2_rsfwd", bus.RSfwd_o, 32'h33);
    check("t2_rthit", 32'(bus.RThit_o), 32'd1);
    check("t2_rtfwd", bus.RTfwd_o, 32'h22);

    // Drain in order
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
      #1;
      check("t3_count", 32'(bus.count_o), 32'(2 - k));
    end
    check("t3_r5", rf_dut[5], 32'h33);
    check("t3_r6", rf_dut[6], 32'h22);

    // Full queue holds off the fifth request until a slot frees
    for (int k = 0; k < 4; k++) cycle(1'b1, 5'(k + 1), 32'hA0 + 32'(k), 1'b0, 5'd1, 5'd4);
    #1;
    check("t4_full_ready", 32'(bus.wb_ready_o), 32'd0);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd1);
    #1;
    check("t4_ready_back", 32'(bus.wb_ready_o), 32'd1);
    check("t4_count_after_pop", 32'(bus.count_o), 32'd3);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd1);
    #1;
    check("t4_count_refill", 32'(bus.count_o), 32'd4);
    check("t4_r9_hit", 32'(bus.RShit_o), 32'd1);
    drain();
    check("t4_r1", rf_dut[1], 32'hA0);
    check("t4_r4", rf_dut[4], 32'hA3);
    check("t4_r9", rf_dut[9], 32'h99);

    // Writes to $0 are swallowed
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0);
    #1;
    check("t5_count", 32'(bus.count_o), 32'd0);
    check("t5_rshit", 32'(bus.RShit_o), 32'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);

    // Asynchronous reset in the middle of a drain
    cycle(1'b1, 5'd7, 32'h70, 1'b0, 5'd7, 5'd8);
    cycle(1'b1, 5'd8, 32'h80, 1'b0, 5'd7, 5'd8);
    cycle(1'b1, 5'd7, 32'h71, 1'b0, 5'd7, 5'd8);
    @(negedge clk);
    bus.wb_valid_i = 1'b0;
    bus.port_en_i  = 1'b1;
    #1;
    check("t1_regwrite_pre", 32'(bus.RegWrite_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t1_regwrite", 32'(bus.RegWrite_o), 32'd0);
    check("t1_count", 32'(bus.count_o), 32'd0);
    check("t1_ready", 32'(bus.wb_ready_o), 32'd1);
    check("t1_rshit", 32'(bus.RShit_o), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    check("t1_count_hold", 32'(bus.count_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t1_r7_untouched", rf_dut[7], rf_ref[7]);

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      v  = ($urandom_range(0, 99) < 60);
      pe = ($urandom_range(0, 99) < 50);
      a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs = 5'($urandom_range(0, 7));
      rt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cycle(v, a, $urandom, pe, rs, rt);
    end
    drain();
    compare_rf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
